// File: rtl/cache.sv
// cache: blocking direct-mapped read-only cache with in-order sideband responses.
// Define CACHE_STATS_EN to add the hit_cnt/miss_cnt counter outputs.
module cache #(
    parameter int SIDE_W  = 8,
    parameter int BLK_W   = 2,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 8,
    parameter int ADDR_W  = 32,
    parameter int RDATA_W = 128,
    parameter int DS_W    = SIDE_W + RDATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SIDE_W-1:0]  us_sb_data,
    input  logic               us_valid,
    input  logic [ADDR_W-1:0]  us_addr,
    output logic               us_stall,
    input  logic [RDATA_W-1:0] from_mh_data,
    input  logic               from_mh_valid,
    output logic               to_mh_stall,
    output logic [ADDR_W-1:0]  to_mh_addr,
    output logic               to_mh_valid,
    input  logic               from_mh_stall,
    output logic [DS_W-1:0]    ds_data,
    output logic               ds_valid,
    input  logic               ds_stall
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_HI = TAG_W + INDEX_W + BLK_W - 1;
    localparam int IDX_HI = INDEX_W + BLK_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [RDATA_W-1:0] data_q [LINES];
    logic [DS_W-1:0]    ds_q, ds_d;
    logic               ds_valid_q, ds_valid_d;
    logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
    logic [SIDE_W-1:0]  miss_sb_q, miss_sb_d;
    logic [TAG_W-1:0]   us_tag;
    logic [INDEX_W-1:0] us_idx, miss_idx;
    logic               hold, hit, accept, fill;
    logic               unused_addr;

    assign unused_addr = ^us_addr;
    assign ds_data     = ds_q;
    assign ds_valid    = ds_valid_q;

    always_comb begin
        us_tag      = us_addr[TAG_HI -: TAG_W];
        us_idx      = us_addr[IDX_HI -: INDEX_W];
        miss_idx    = miss_addr_q[IDX_HI -: INDEX_W];
        hold        = ds_valid_q & ds_stall;
        us_stall    = (state_q != S_IDLE) | hold;
        hit         = valid_q[us_idx] & (tag_q[us_idx] == us_tag);
        accept      = us_valid & ~us_stall;
        to_mh_valid = state_q == S_REQ;
        to_mh_addr  = miss_addr_q;
        to_mh_stall = (state_q == S_WAIT) & hold;
        fill        = (state_q == S_WAIT) & from_mh_valid & ~to_mh_stall;
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        miss_sb_d   = miss_sb_q;
        valid_d     = valid_q;
        if (accept && !hit) begin
            state_d     = S_REQ;
            miss_addr_d = us_addr;
            miss_sb_d   = us_sb_data;
        end
        if (state_q == S_REQ && !from_mh_stall) state_d = S_WAIT;
        if (fill) begin
            state_d           = S_IDLE;
            valid_d[miss_idx] = 1'b1;
        end
        // A stalled response must stay put; accept and fill are exclusive by state.
        ds_valid_d = hold | (accept & hit) | fill;
        ds_d = hold           ? ds_q :
               (accept & hit) ? {us_sb_data, data_q[us_idx]} :
               fill           ? {miss_sb_q, from_mh_data} : ds_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            ds_q        <= '0;
            ds_valid_q  <= 1'b0;
            miss_addr_q <= '0;
            miss_sb_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ds_q        <= ds_d;
            ds_valid_q  <= ds_valid_d;
            miss_addr_q <= miss_addr_d;
            miss_sb_q   <= miss_sb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_addr_q[TAG_HI -: TAG_W];
            data_q[miss_idx] <= from_mh_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'b0, accept & hit};
        miss_cnt_d = miss_cnt_q + {31'b0, accept & ~hit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache.sv
// tb_cache: directed bench for cache with a scoreboard queue of expected {sideband, line} responses
// and a behavioural miss handler whose line data is a function of the tag+index address bits.
module tb_cache;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   us_sb_data = '0;
    logic         us_valid = 1'b0;
    logic [31:0]  us_addr = '0;
    logic         us_stall;
    logic [127:0] from_mh_data = '0;
    logic         from_mh_valid = 1'b0;
    logic         to_mh_stall;
    logic [31:0]  to_mh_addr;
    logic         to_mh_valid;
    logic         from_mh_stall = 1'b0;
    logic [135:0] ds_data;
    logic         ds_valid;
    logic         ds_stall = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    cache dut (
        .clk(clk), .rst(rst), .us_sb_data(us_sb_data), .us_valid(us_valid), .us_addr(us_addr),
        .us_stall(us_stall), .from_mh_data(from_mh_data), .from_mh_valid(from_mh_valid),
        .to_mh_stall(to_mh_stall), .to_mh_addr(to_mh_addr), .to_mh_valid(to_mh_valid),
        .from_mh_stall(from_mh_stall), .ds_data(ds_data), .ds_valid(ds_valid), .ds_stall(ds_stall)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    logic [135:0] exp_q [$];
    int checks = 0, failures = 0, resp_n = 0, mh_reqs = 0;
    int ds_mode = 0, mh_lat = 3, mh_cnt = 0, m_hit = 0, m_miss = 0;
    int w, base, mb;
    logic [31:0]  mh_last = '0, mh_addr = '0, ta, a;
    logic         mh_pend = 1'b0, tr, tf, prev_hold = 1'b0;
    logic [135:0] prev_data = '0;
    logic         m_v [64];
    logic [7:0]   m_t [64];

    localparam logic [31:0] A = 32'h1234_5678;
    localparam logic [31:0] X = 32'h0000_33C0;
    localparam logic [31:0] Y = 32'hABCD_77C4;
    localparam logic [31:0] Z = 32'h0000_88C8;

    function automatic logic [127:0] mem_f(input logic [31:0] ad);
        logic [31:0] x;
        x = {18'h0, ad[15:2]};
        return {x ^ 32'hDEAD_0000, x * 32'h0100_0193, ~x, x + 32'h1234_5678};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] ad, input logic [7:0] sb, output int waits);
        logic acc;
        logic [5:0] idx;
        logic [7:0] tg;
        acc = 1'b0;
        waits = 0;
        us_valid = 1'b1;
        us_addr = ad;
        us_sb_data = sb;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!us_stall) begin
                acc = 1'b1;
                break;
            end
            waits++;
        end
        chk("accept", acc, 1);
        exp_q.push_back({sb, mem_f(ad)});
        idx = ad[7:2];
        tg = ad[15:8];
        if (m_v[idx] && m_t[idx] == tg) m_hit++;
        else begin
            m_miss++;
            m_v[idx] = 1'b1;
            m_t[idx] = tg;
        end
        @(posedge clk);
        #1;
        us_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Downstream back-pressure: 0 = none, 1 = random, 2 = held.
    initial forever begin
        @(posedge clk);
        #1;
        ds_stall = ds_mode == 1 ? 1'($urandom_range(0, 1)) : ds_mode == 2;
    end

    // Miss handler: takes one request, fills after mh_lat cycles, holds the fill until taken.
    initial forever begin
        @(negedge clk);
        tr = to_mh_valid && !from_mh_stall;
        tf = from_mh_valid && !to_mh_stall;
        ta = to_mh_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            mh_pend = 1'b0;
            from_mh_valid = 1'b0;
        end else begin
            if (tf) begin
                from_mh_valid = 1'b0;
                mh_pend = 1'b0;
            end
            if (tr) begin
                mh_pend = 1'b1;
                mh_cnt = mh_lat;
                mh_addr = ta;
                mh_last = ta;
                mh_reqs++;
            end else if (mh_pend && !from_mh_valid) begin
                if (mh_cnt <= 1) begin
                    from_mh_valid = 1'b1;
                    from_mh_data = mem_f(mh_addr);
                end else mh_cnt--;
            end
        end
    end

    // Response monitor: scoreboard pop on each transfer, plus stability while stalled.
    initial forever begin
        @(negedge clk);
        if (rst) prev_hold = 1'b0;
        else begin
            if (prev_hold) begin
                chk("hold_valid", ds_valid, 1);
                chk("hold_data", ds_data, prev_data);
            end
            if (ds_valid && !ds_stall) begin
                resp_n++;
                if (exp_q.size() == 0) chk("resp_expected", 0, 1);
                else chk("resp", ds_data, exp_q.pop_front());
            end
            prev_hold = ds_valid && ds_stall;
            prev_data = ds_data;
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ds_valid", ds_valid, 0);
        chk("rst_ds_data", ds_data, 0);
        chk("rst_to_mh_valid", to_mh_valid, 0);
        chk("rst_to_mh_addr", to_mh_addr, 0);
        chk("rst_us_stall", us_stall, 0);
        chk("rst_to_mh_stall", to_mh_stall, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = mh_reqs;
        for (int i = 0; i < 10; i++) begin
            rd(A, 8'd0, w);
            if (i >= 2) chk("hit_back_to_back", w, 0);
        end
        drain();
        chk("p1_mh_reqs", mh_reqs - base, 1);
        chk("p1_mh_addr", mh_last, A);
        chk("p1_resps", resp_n, 10);
`ifdef CACHE_STATS_EN
        chk("p1_hit_cnt", hit_cnt, 9);
        chk("p1_miss_cnt", miss_cnt, 1);
`endif
        ds_mode = 1;
        mh_lat = 80;
        base = mh_reqs;
        mb = m_miss;
        for (int i = 1; i <= 20; i++) begin
            a = $urandom;
            a[15:8] = 8'($urandom_range(0, 2));
            a[7:2] = 6'($urandom_range(1, 4));
            rd(a, 8'(i), w);
        end
        ds_mode = 0;
        drain();
        chk("p2_resps", resp_n, 30);
        chk("p2_mh_reqs", mh_reqs - base, m_miss - mb);
`ifdef CACHE_STATS_EN
        chk("p2_hit_cnt", hit_cnt, m_hit);
        chk("p2_miss_cnt", miss_cnt, m_miss);
`endif
        mh_lat = 3;
        base = mh_reqs;
        rd(32'h0000_0000, 8'd21, w);
        rd(32'h0000_0400, 8'd22, w);
        rd(32'h0000_0000, 8'd23, w);
        drain();
        chk("evict_mh_reqs", mh_reqs - base, 3);
        from_mh_stall = 1'b1;
        base = mh_reqs;
        rd(X, 8'd24, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mh_stall_valid", to_mh_valid, 1);
            chk("mh_stall_addr", to_mh_addr, X);
            @(posedge clk);
            #1;
        end
        from_mh_stall = 1'b0;
        drain();
        chk("mh_stall_reqs", mh_reqs - base, 1);
        ds_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        rd(Y, 8'd25, w);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (from_mh_valid) break;
        end
        chk("fill_seen", from_mh_valid, 1);
        chk("fill_to_mh_stall", to_mh_stall, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_ds_valid", ds_valid, 1);
        chk("stall_us_stall", us_stall, 1);
        chk("stall_ds_data", ds_data, {8'd25, mem_f(Y)});
        repeat (4) @(posedge clk);
        #1;
        ds_mode = 0;
        drain();
        mh_lat = 50;
        rd(Z, 8'd26, w);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ds_valid", ds_valid, 0);
        chk("arst_us_stall", us_stall, 0);
        chk("arst_to_mh_valid", to_mh_valid, 0);
        chk("arst_to_mh_stall", to_mh_stall, 0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mh_lat = 3;
        @(posedge clk);
        #1;
        base = mh_reqs;
        rd(Z, 8'd27, w);
        drain();
        chk("rerun_mh_reqs", mh_reqs - base, 1);
        chk("rerun_mh_addr", mh_last, Z);
`ifdef CACHE_STATS_EN
        chk("rerun_hit_cnt", hit_cnt, 0);
        chk("rerun_miss_cnt", miss_cnt, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
